// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback sequencer for the 16-bit datapath.
// Drives the ALU opcode/operand interface, writes results back and keeps the status flags.
module instr_sequencer #(
    parameter int unsigned          DATA_W   = 16,
    parameter logic [DATA_W-1:0]    PC_RESET = '0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    output logic              o_mem_rd_en,
    output logic [DATA_W-1:0] o_mem_addr,
    input  logic [DATA_W-1:0] i_mem_rdata,
    input  logic              i_mem_valid,
    output logic [3:0]        o_rf_ra,
    output logic [3:0]        o_rf_rb,
    input  logic [DATA_W-1:0] i_rf_rdata_a,
    input  logic [DATA_W-1:0] i_rf_rdata_b,
    output logic              o_rf_we,
    output logic [3:0]        o_rf_wa,
    output logic [DATA_W-1:0] o_rf_wdata,
    output logic [DATA_W-1:0] o_alu_a,
    output logic [DATA_W-1:0] o_alu_b,
    output logic [7:0]        o_alu_op,
    input  logic [DATA_W-1:0] i_alu_c,
    input  logic [4:0]        i_alu_flags,
    output logic [4:0]        o_flags,
    output logic [DATA_W-1:0] o_pc,
    output logic              o_halted,
    input  logic              i_go
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK,
        S_HALT
    } state_t;

    typedef enum logic [2:0] {
        C_NOP,
        C_ALU,
        C_CMP,
        C_MOV,
        C_IMM,
        C_BR
    } cls_t;

    localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

    state_t            r_state;
    state_t            w_state_nxt;
    cls_t              r_cls;
    cls_t              w_cls;
    logic [DATA_W-1:0] r_pc;
    logic [DATA_W-1:0] r_ir;
    logic [4:0]        r_flags;
    logic [DATA_W-1:0] r_opa;
    logic [DATA_W-1:0] r_opb;
    logic [7:0]        r_alu_op;
    logic [DATA_W-1:0] r_res;
    logic [4:0]        r_fl;

    logic [3:0]        w_op;
    logic [3:0]        w_ext;
    logic [DATA_W-1:0] w_sext;
    logic [DATA_W-1:0] w_zext;
    logic [DATA_W-1:0] w_opb;
    logic [7:0]        w_alu_op;
    logic              w_taken;
    logic              w_z, w_c, w_f, w_n, w_l;

    assign w_op   = r_ir[15:12];
    assign w_ext  = r_ir[7:4];
    assign w_sext = {{(DATA_W-8){r_ir[7]}}, r_ir[7:0]};
    assign w_zext = {{(DATA_W-8){1'b0}}, r_ir[7:0]};

    assign {w_z, w_c, w_f, w_n, w_l} = r_flags;

    // Class and second operand; MOVI/LUI park their write data in operand b
    always_comb begin
        w_cls    = C_NOP;
        w_alu_op = '0;
        w_opb    = i_rf_rdata_b;
        unique case (w_op)
            4'h0: begin
                if (w_ext == 4'hD) begin
                    w_cls = C_MOV;
                end else begin
                    w_cls    = (w_ext == 4'hB) ? C_CMP : C_ALU;
                    w_alu_op = {w_op, w_ext};
                end
            end
            4'h8: begin
                w_cls    = C_ALU;
                w_alu_op = {w_op, w_ext};
            end
            4'h5, 4'h7, 4'h9: begin
                w_cls    = C_ALU;
                w_alu_op = {4'h0, w_op};
                w_opb    = w_sext;
            end
            4'hB: begin
                w_cls    = C_CMP;
                w_alu_op = {4'h0, w_op};
                w_opb    = w_sext;
            end
            4'h1, 4'h2, 4'h3, 4'h6: begin
                w_cls    = C_ALU;
                w_alu_op = {4'h0, w_op};
                w_opb    = w_zext;
            end
            4'hD: begin
                w_cls = C_IMM;
                w_opb = w_zext;
            end
            4'hF: begin
                w_cls = C_IMM;
                w_opb = w_zext << 8;
            end
            4'hC: w_cls = C_BR;
            default: w_cls = C_NOP;
        endcase
    end

    always_comb begin
        case (r_ir[11:8])
            4'h0: w_taken = w_z;
            4'h1: w_taken = !w_z;
            4'h2: w_taken = w_c;
            4'h3: w_taken = !w_c;
            4'h4: w_taken = w_l;
            4'h5: w_taken = !w_l;
            4'h6: w_taken = w_n;
            4'h7: w_taken = !w_n;
            4'h8: w_taken = w_f;
            4'h9: w_taken = !w_f;
            4'hA: w_taken = !w_l && !w_z;
            4'hB: w_taken = w_l || w_z;
            4'hC: w_taken = !w_n && !w_z;
            4'hD: w_taken = w_n || w_z;
            4'hE: w_taken = 1'b1;
            default: w_taken = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Strobes are masked while reset is high so nothing escapes in the reset cycle
    always_comb begin
        w_state_nxt = r_state;
        o_mem_rd_en = 1'b0;
        o_rf_we     = 1'b0;
        o_halted    = 1'b0;
        unique case (r_state)
            S_FETCH: begin
                o_mem_rd_en = !i_reset;
                if (i_mem_valid) begin
                    w_state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                w_state_nxt = (r_ir == '0) ? S_HALT : S_EXECUTE;
            end
            S_EXECUTE: begin
                w_state_nxt = S_WRITEBACK;
            end
            S_WRITEBACK: begin
                o_rf_we = !i_reset &&
                          (r_cls == C_ALU || r_cls == C_MOV || r_cls == C_IMM);
                w_state_nxt = S_FETCH;
            end
            S_HALT: begin
                o_halted = 1'b1;
                if (i_go) begin
                    w_state_nxt = S_FETCH;
                end
            end
            default: w_state_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pc     <= PC_RESET;
            r_ir     <= '0;
            r_flags  <= '0;
            r_opa    <= '0;
            r_opb    <= '0;
            r_alu_op <= '0;
            r_res    <= '0;
            r_fl     <= '0;
            r_cls    <= C_NOP;
        end else begin
            unique case (r_state)
                S_FETCH: begin
                    if (i_mem_valid) begin
                        r_ir <= i_mem_rdata;
                    end
                end
                S_DECODE: begin
                    r_opa    <= i_rf_rdata_a;
                    r_opb    <= w_opb;
                    r_alu_op <= w_alu_op;
                    r_cls    <= w_cls;
                end
                S_EXECUTE: begin
                    r_res <= i_alu_c;
                    r_fl  <= i_alu_flags;
                end
                S_WRITEBACK: begin
                    if (r_cls == C_ALU || r_cls == C_CMP) begin
                        r_flags <= r_fl;
                    end
                    if (r_cls == C_BR && w_taken) begin
                        r_pc <= r_pc + w_sext;
                    end else begin
                        r_pc <= r_pc + ONE;
                    end
                end
                S_HALT: begin
                    if (i_go) begin
                        r_pc <= r_pc + ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_mem_addr = r_pc;
    assign o_pc       = r_pc;
    assign o_rf_ra    = r_ir[11:8];
    assign o_rf_rb    = r_ir[3:0];
    assign o_rf_wa    = r_ir[11:8];
    assign o_rf_wdata = (r_cls == C_ALU) ? r_res : r_opb;
    assign o_alu_a    = r_opa;
    assign o_alu_b    = r_opb;
    assign o_alu_op   = r_alu_op;
    assign o_flags    = r_flags;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: instruction-level reference model, regfile and ALU stub,
// directed scenarios followed by randomized instruction streams.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_rd_en;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata;
    logic        mem_valid;
    logic [3:0]  rf_ra, rf_rb, rf_wa;
    logic [15:0] rf_rdata_a, rf_rdata_b, rf_wdata;
    logic        rf_we;
    logic [15:0] alu_a, alu_b, alu_c;
    logic [7:0]  alu_op;
    logic [4:0]  alu_flags;
    logic [4:0]  flags;
    logic [15:0] pc;
    logic        halted;
    logic        go;

    always #5 clk = ~clk;

    instr_sequencer #(.DATA_W(16), .PC_RESET(16'h0000)) dut (
        .i_clk(clk), .i_reset(rst),
        .o_mem_rd_en(mem_rd_en), .o_mem_addr(mem_addr),
        .i_mem_rdata(mem_rdata), .i_mem_valid(mem_valid),
        .o_rf_ra(rf_ra), .o_rf_rb(rf_rb),
        .i_rf_rdata_a(rf_rdata_a), .i_rf_rdata_b(rf_rdata_b),
        .o_rf_we(rf_we), .o_rf_wa(rf_wa), .o_rf_wdata(rf_wdata),
        .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_op(alu_op),
        .i_alu_c(alu_c), .i_alu_flags(alu_flags),
        .o_flags(flags), .o_pc(pc), .o_halted(halted), .i_go(go)
    );

    // Register file and ALU stub seen by the DUT
    logic [15:0] rf [16];
    logic        f_en;
    logic [4:0]  f_val;

    function automatic logic [15:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                           input logic [7:0] op);
        if (op == 8'h05) return a + b;
        return (a ^ {b[7:0], b[15:8]}) + {8'h00, op};
    endfunction

    function automatic logic [4:0] fl_fn(input logic [15:0] a, input logic [15:0] b,
                                         input logic [7:0] op);
        return a[4:0] ^ b[9:5] ^ op[4:0];
    endfunction

    assign rf_rdata_a = rf[rf_ra];
    assign rf_rdata_b = rf[rf_rb];
    assign alu_c      = alu_fn(alu_a, alu_b, alu_op);
    assign alu_flags  = f_en ? f_val : fl_fn(alu_a, alu_b, alu_op);

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Expected per-cycle outputs, posted by the stimulus before each negedge
    logic        chk_en = 1'b0;
    logic        e_rd_en, e_halted, e_we, e_alu_chk;
    logic [15:0] e_addr, e_pc, e_wdata, e_a, e_b;
    logic [3:0]  e_wa;
    logic [4:0]  e_flags;
    logic [7:0]  e_op;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("mem_rd_en", mem_rd_en, e_rd_en);
            if (e_rd_en) chk("mem_addr", mem_addr, e_addr);
            chk("halted", halted, e_halted);
            chk("rf_we", rf_we, e_we);
            if (e_we) begin
                chk("rf_wa", rf_wa, e_wa);
                chk("rf_wdata", rf_wdata, e_wdata);
            end
            chk("pc", pc, e_pc);
            chk("flags", flags, e_flags);
            if (e_alu_chk) begin
                chk("alu_op", alu_op, e_op);
                chk("alu_a", alu_a, e_a);
                chk("alu_b", alu_b, e_b);
            end
        end
    end

    // Architectural state of the reference model
    logic [15:0] m_pc;
    logic [4:0]  m_fl;

    // Prediction for one instruction
    logic        p_halt, p_alu, p_wr, p_upd;
    logic [7:0]  p_aop;
    logic [15:0] p_av, p_bv, p_wd, p_npc;
    logic [4:0]  p_nf;
    logic [3:0]  p_rd;

    // DUT snapshots for literal checks
    logic [7:0]  s_op;
    logic [15:0] s_a, s_b, s_wdata;
    logic        s_we;

    function automatic bit cond_ok(input logic [3:0] c, input logic [4:0] f);
        bit z, cy, ff, n, l;
        {z, cy, ff, n, l} = f;
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cy;
            4'h3: return !cy;
            4'h4: return l;
            4'h5: return !l;
            4'h6: return n;
            4'h7: return !n;
            4'h8: return ff;
            4'h9: return !ff;
            4'hA: return !l && !z;
            4'hB: return l || z;
            4'hC: return !n && !z;
            4'hD: return n || z;
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic predict(input logic [15:0] ins);
        logic [3:0]  op, ext, rs;
        logic [15:0] sx, zx;
        op = ins[15:12];
        ext = ins[7:4];
        rs = ins[3:0];
        p_rd = ins[11:8];
        sx = {{8{ins[7]}}, ins[7:0]};
        zx = {8'h00, ins[7:0]};
        p_halt = (ins == 16'h0000);
        p_alu = 0; p_wr = 0; p_upd = 0;
        p_aop = 0; p_bv = 0; p_wd = 0; p_nf = m_fl;
        p_av = rf[p_rd];
        p_npc = m_pc + 16'd1;
        case (op)
            4'h0, 4'h8: begin
                if (op == 4'h0 && ext == 4'hD) begin
                    p_wr = 1; p_wd = rf[rs];
                end else begin
                    p_alu = 1; p_upd = 1; p_aop = {op, ext}; p_bv = rf[rs];
                    p_wr = !(op == 4'h0 && ext == 4'hB);
                end
            end
            4'h5, 4'h7, 4'h9, 4'hB: begin
                p_alu = 1; p_upd = 1; p_aop = {4'h0, op}; p_bv = sx;
                p_wr = (op != 4'hB);
            end
            4'h1, 4'h2, 4'h3, 4'h6: begin
                p_alu = 1; p_upd = 1; p_aop = {4'h0, op}; p_bv = zx; p_wr = 1;
            end
            4'hD: begin p_wr = 1; p_wd = zx; end
            4'hF: begin p_wr = 1; p_wd = {ins[7:0], 8'h00}; end
            4'hC: if (cond_ok(p_rd, m_fl)) p_npc = m_pc + sx;
            default: ;
        endcase
        if (p_alu) begin
            p_wd = alu_fn(p_av, p_bv, p_aop);
            p_nf = f_en ? f_val : fl_fn(p_av, p_bv, p_aop);
        end
        if (!p_upd) p_nf = m_fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic base();
        e_rd_en = 0; e_halted = 0; e_we = 0; e_alu_chk = 0;
        e_addr = m_pc; e_pc = m_pc; e_flags = m_fl;
        e_wa = 0; e_wdata = 0; e_op = 0; e_a = 0; e_b = 0;
    endtask

    // Runs one instruction from FETCH; called just after a rising edge
    task automatic exec(input logic [15:0] ins, input int dly, input int hcyc,
                        input bit rst_ex);
        predict(ins);
        for (int i = 0; i <= dly; i++) begin
            mem_valid = (i == dly);
            mem_rdata = (i == dly) ? ins : 16'($urandom);
            go = 1'($urandom);
            base();
            e_rd_en = 1;
            step();
        end
        mem_valid = 1'($urandom);
        mem_rdata = 16'($urandom);
        go = 1'($urandom);
        base();
        step();
        if (p_halt) begin
            go = 0;
            for (int i = 0; i < hcyc; i++) begin
                mem_valid = 1'($urandom);
                base();
                e_halted = 1;
                step();
            end
            go = 1;
            base();
            e_halted = 1;
            step();
            go = 0;
            m_pc = m_pc + 16'd1;
            return;
        end
        mem_valid = 1'($urandom);
        go = 1'($urandom);
        base();
        e_alu_chk = p_alu;
        e_op = p_aop; e_a = p_av; e_b = p_bv;
        s_op = alu_op; s_a = alu_a; s_b = alu_b;
        if (rst_ex) rst = 1;
        step();
        if (rst_ex) begin
            rst = 0;
            m_pc = 16'h0000;
            m_fl = 5'b0;
            return;
        end
        mem_valid = 1'($urandom);
        go = 1'($urandom);
        base();
        e_we = p_wr; e_wa = p_rd; e_wdata = p_wd;
        s_we = rf_we; s_wdata = rf_wdata;
        step();
        if (p_wr) rf[p_rd] = p_wd;
        m_fl = p_nf;
        m_pc = p_npc;
    endtask

    logic [4:0]  fl_prev;
    logic [15:0] ins;

    initial begin
        rst = 1; mem_valid = 0; mem_rdata = 0; go = 0;
        f_en = 0; f_val = 0;
        for (int i = 0; i < 16; i++) rf[i] = 16'h0000;
        m_pc = 16'h0000; m_fl = 5'b0;
        step();
        base();
        e_alu_chk = 1;
        chk_en = 1;
        step();
        rst = 0;

        // ADD r1,r2 with r1=3, r2=4
        rf[1] = 16'd3; rf[2] = 16'd4;
        exec(16'h0152, 0, 0, 0);
        chk("add_op", s_op, 8'h05);
        chk("add_a", s_a, 16'd3);
        chk("add_b", s_b, 16'd4);
        chk("add_wdata", s_wdata, 16'd7);
        chk("add_flags", flags, 5'b00110);
        chk("add_pc", pc, 16'h0001);

        exec(16'h51FF, 0, 0, 0);
        chk("addi_b", s_b, 16'hFFFF);
        exec(16'h11F0, 0, 0, 0);
        chk("andi_b", s_b, 16'h00F0);
        fl_prev = m_fl;
        exec(16'hF1AB, 0, 0, 0);
        chk("lui_wdata", s_wdata, 16'hAB00);
        chk("lui_flags", flags, fl_prev);

        f_en = 1; f_val = 5'b00011;
        exec(16'h01B2, 0, 0, 0);
        chk("cmp_flags", flags, 5'b00011);
        chk("cmp_we", s_we, 1'b0);
        exec(16'hCE0B, 0, 0, 0);
        chk("bal_pc", pc, 16'h0010);
        exec(16'hC6FC, 0, 0, 0);
        chk("bgt_pc", pc, 16'h000C);
        exec(16'hCE04, 0, 0, 0);
        exec(16'hC0FC, 0, 0, 0);
        chk("beq_pc", pc, 16'h0011);
        f_en = 0;

        exec(16'h0152, 3, 0, 0);
        chk("late_pc", pc, 16'h0012);
        exec(16'h0000, 0, 10, 0);
        chk("halt_pc", pc, 16'h0013);

        exec(16'h0152, 0, 0, 1);
        chk("rst_pc", pc, 16'h0000);
        chk("rst_flags", flags, 5'b0);
        chk("rst_alu_op", alu_op, 8'h00);
        chk("rst_alu_a", alu_a, 16'h0000);

        exec(16'hCEFF, 0, 0, 0);
        chk("wrap_hi", pc, 16'hFFFF);
        exec(16'h4123, 1, 0, 0);
        chk("wrap_pc", pc, 16'h0000);

        for (int i = 0; i < 16; i++) rf[i] = 16'($urandom);
        for (int n = 0; n < 400; n++) begin
            ins = 16'($urandom);
            if ($urandom_range(0, 30) == 0) ins = 16'h0000;
            else if (ins == 16'h0000) ins = 16'h0001;
            f_en = ($urandom_range(0, 3) == 0);
            f_val = 5'($urandom);
            exec(ins, ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0,
                 int'($urandom_range(0, 4)), $urandom_range(0, 40) == 0);
        end

        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Multi-cycle fetch/decode/execute/writeback controller for the 16-bit datapath. It fetches instruction words from memory and decodes them into ALU opcode and operands, register-file addresses and immediates. It consumes the ALU result and ZCFNL flags, writes results back and latches the flags in a processor status register. It also evaluates conditional branches against those latched flags, so it is the driving and consuming end of the ALU's opcode/operand/result/flags interface.

## Interface
- DATA_W, 16, datapath, instruction and address width
- PC_RESET, 16'h0000, PC value loaded on reset
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; takes effect at the next rising edge
- mem_rd_en  out  1  instruction read request, high only in FETCH
- mem_addr  out  16  word address of fetch (= pc)
- mem_rdata  in  16  instruction word
- mem_valid  in  1  mem_rdata valid this cycle; sampled only in FETCH
- rf_ra, rf_rb  out  4  read addresses (Rdest, Rsrc); regfile reads are combinational
- rf_rdata_a, rf_rdata_b  in  16  read data
- rf_we  out  1  write strobe, one cycle in WRITEBACK
- rf_wa  out  4  write address (= ir[11:8])
- rf_wdata  out  16  write data
- alu_a, alu_b  out  16  ALU operands
- alu_op  out  8  ALU opcode
- alu_c  in  16  ALU result
- alu_flags  in  5  ALU flags {Z,C,F,N,L}, bits 4..0
- flags  out  5  latched status register
- pc  out  16  current program counter
- halted  out  1  high while in HALT
- go  in  1  resume pulse from HALT

## Operation
- States: FETCH, DECODE, EXECUTE, WRITEBACK, HALT.
- FETCH: mem_rd_en=1, mem_addr=pc. On mem_valid: ir<=mem_rdata, go to DECODE. Otherwise hold, with addr stable.
- DECODE: operand_a<=rf_rdata_a (rf_ra=ir[11:8]), operand_b<=rf_rdata_b (rf_rb=ir[3:0]) or the extended immediate. Class is latched from ir[15:12]. ir==16'h0000 goes to HALT, otherwise to EXECUTE.
- Encodings: [15:12] op, [11:8] Rdest/cond, [7:4] ext, [3:0] Rsrc; I-type imm8=ir[7:0].
- R-type (op 0000) and shift group (op 1000): alu_op={op,ext}, alu_b=Rsrc data.
- I-type ops 0101 ADDI, 0111 ADDCI, 1001 SUBI, 1011 CMPI: alu_op={4'h0,op}, alu_b=sign-extended imm8.
- I-type ops 0001 ANDI, 0010 ORI, 0011 XORI, 0110 ADDUI: alu_op={4'h0,op}, alu_b=zero-extended imm8.
- MOV (op 0000, ext 1101): rf_wdata=Rsrc data; no ALU; flags unchanged.
- MOVI (1101): rf_wdata={8'h00,imm8}. LUI (1111): rf_wdata={imm8,8'h00}. Both leave flags unchanged.
- Bcond (1100): cond=ir[11:8], disp=sext(ir[7:0]). Taken means pc<=pc+disp; else pc<=pc+1. No rf or flag write.
- Conditions on latched flags: 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 HI L; 5 LS !L; 6 GT N; 7 LE !N; 8 FS F; 9 FC !F; A LO !L&!Z; B HS L|Z; C LT !N&!Z; D GE N|Z; E always; F never.
- EXECUTE: alu_a/alu_b/alu_op driven from latched operands. res<=alu_c, fl<=alu_flags.
- WRITEBACK for ALU ops: flags<=fl, rf_we=1 with rf_wdata=res. CMP (0000/1011) and CMPI update flags only, with no rf_we.
- WRITEBACK for MOV/MOVI/LUI: rf_we=1.
- WRITEBACK pc update: pc<=pc+1 except for taken branches. pc wraps 16'hFFFF->0.
- Undefined op/ext: treated as NOP (no writes, pc+1).
- HALT: halted=1, mem_rd_en=0. When go=1: pc<=pc+1, go to FETCH. go is ignored outside HALT.
- Reset values: state FETCH, pc=PC_RESET, ir=0, flags=0, rf_we=0, mem_rd_en=0 in reset cycle, halted=0, alu_op=0, alu_a=alu_b=0.

## Timing
- Zero-wait fetch (mem_valid in first FETCH cycle): exactly 4 cycles per instruction; HALT entry at the end of DECODE.
- Each cycle mem_valid is late adds one cycle. mem_rd_en and mem_addr are held constant until it arrives.
- rf_we is high for exactly one cycle per writing instruction.
- New flags are visible the cycle after WRITEBACK, so a Bcond following CMP sees the CMP's flags.
- Reset in any state, including mid-FETCH or EXECUTE: no rf_we and no flag/pc update in that cycle; FETCH at PC_RESET on the next cycle.

## Test plan
- Reset, r1=3, r2=4, fetch 0x0152 (ADD) -> alu_op=0x05, alu_a=3, alu_b=4; WRITEBACK rf_wa=1, rf_wdata=7, rf_we for 1 cycle; flags=ALU stub value; pc 0->1 after 4 cycles.
- Fetch 0x51FF (ADDI r1,-1) -> alu_b=0xFFFF. Fetch 0x11F0 (ANDI) -> alu_b=0x00F0. Fetch 0xF1AB (LUI r1) -> rf_wdata=0xAB00, flags unchanged.
- CMP 0x01B2 with ALU stub flags 5'b00011 -> flags=5'b00011, rf_we never high. Then 0xC6FC at pc=0x10 (BGT -4) -> pc=0x0C. 0xC0FC (BEQ) -> pc=0x11.
- mem_valid delayed 3 cycles -> mem_rd_en and mem_addr stable for 4 cycles; instruction completes in 7 cycles.
- Fetch 0x0000 -> halted=1, mem_rd_en=0 for 10 cycles. Pulse go -> halted=0, next fetch at pc+1.
- Assert reset during EXECUTE of ADD -> no rf_we; pc=PC_RESET, flags=0; next cycle mem_rd_en=1, mem_addr=0.
